if_stage: RTL and testbench

- Instruction-fetch stage: owns the PC, drives the instruction-SRAM request channel, and holds a one-entry IF/ID latch.
- Supplies instruction and PC (plus valid and address-error flag) to the decode stage.
- Consumes decode's redirect outputs (pcsource, bpc, jpc, jrpc) and stall, plus an exception flush from CP0.
- Allows at most one outstanding fetch and handles branch delay slots.

---
 rtl/if_stage.sv | 133 +++++++++++++
 tb/tb_if_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage owning the PC, the instruction-SRAM request channel and a one-entry IF/ID latch
//   clk, reset           clock, asynchronous active-high reset
//   stall                decode cannot accept; the IF/ID latch holds
//   pcsource, bpc/jrpc/jpc  redirect from the instruction currently in decode
//   exc_flush            discard everything in flight, refetch at EXC_PC
//   inst_req/addr, inst_addr_ok/data_ok/rdata  instruction SRAM channel
//   o_inst, o_pc, o_valid, o_adel  IF/ID latch contents toward decode
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] EXC_PC = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jrpc,
  input  logic [31:0] jpc,
  input  logic        exc_flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_valid,
  output logic        o_adel
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic started, cancel, cancel_n, redirect_pending, load, adel_load, skid_load;
  logic id_fire, free, redir, mis;
  logic [31:0] pc, redirect_pc, skid, target, next_pc, word;
  assign id_fire = o_valid & ~stall;
  assign free = ~o_valid | id_fire;
  assign redir = id_fire & |pcsource;
  assign target = pcsource == 2'b01 ? bpc : pcsource == 2'b10 ? jrpc : jpc;
  // pc always names the fetch after the latched word, so a redirect from decode
  // naturally lands after the delay slot
  assign next_pc = redir ? target : redirect_pending ? redirect_pc : pc + 32'd4;
  assign mis = |pc[1:0];
  assign inst_req = started & state == REQ & ~mis;
  assign inst_addr = pc;
  always_comb begin
    state_n = state;
    cancel_n = cancel;
    load = 1'b0;
    adel_load = 1'b0;
    skid_load = 1'b0;
    word = inst_rdata;
    if (exc_flush) begin
      if (state == HOLD) state_n = REQ;
      else if (state == REQ && inst_req && inst_addr_ok) begin
        state_n = WAIT;
        cancel_n = 1'b1;
      end else if (state == WAIT) begin
        // a response arriving with the flush is the outstanding one: drop it now
        if (inst_data_ok) state_n = REQ;
        cancel_n = ~inst_data_ok;
      end
    end else begin
      case (state)
        REQ: begin
          if (mis) begin
            load = started & free;
            adel_load = load;
          end else if (inst_req && inst_addr_ok) state_n = WAIT;
        end
        WAIT: begin
          if (inst_data_ok) begin
            if (cancel) begin
              cancel_n = 1'b0;
              state_n = REQ;
            end else if (free) begin
              load = 1'b1;
              state_n = REQ;
            end else begin
              skid_load = 1'b1;
              state_n = HOLD;
            end
          end
        end
        HOLD: begin
          if (id_fire) begin
            load = 1'b1;
            word = skid;
            state_n = REQ;
          end
        end
        default: state_n = REQ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= REQ;
      started <= 1'b0;
      cancel <= 1'b0;
      pc <= RESET_PC;
      redirect_pending <= 1'b0;
      redirect_pc <= '0;
      skid <= '0;
      o_valid <= 1'b0;
      o_inst <= '0;
      o_pc <= '0;
      o_adel <= 1'b0;
    end else begin
      state <= state_n;
      started <= 1'b1;
      cancel <= cancel_n;
      if (skid_load) skid <= inst_rdata;
      if (exc_flush) begin
        pc <= EXC_PC;
        redirect_pending <= 1'b0;
        o_valid <= 1'b0;
      end else if (load) begin
        pc <= next_pc;
        redirect_pending <= 1'b0;
        o_valid <= 1'b1;
        o_inst <= adel_load ? '0 : word;
        o_pc <= pc;
        o_adel <= adel_load;
      end else begin
        if (redir) begin
          redirect_pending <= 1'b1;
          redirect_pc <= target;
        end
        if (id_fire) o_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: self-checking bench for if_stage with an SRAM slave model and a decode-side reference model
module tb_if_stage;
  localparam logic [31:0] RST = 32'hBFC00000;
  localparam logic [31:0] EXC = 32'hBFC00380;
  logic clk = 1'b0, reset = 1'b1, stall = 1'b0, exc_flush = 1'b0;
  logic inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic [1:0] pcsource = 2'b0;
  logic [31:0] bpc = '0, jrpc = '0, jpc = '0, inst_rdata = '0;
  logic inst_req, o_valid, o_adel;
  logic [31:0] inst_addr, o_inst, o_pc;
  int checks = 0, failures = 0;
  typedef struct packed {logic [31:0] pc; logic [31:0] inst; logic adel;} deliv_t;
  deliv_t dq[$];
  logic [31:0] reqs[$];
  int acc_pct, lat_min, lat_max, pend_cnt, slow_lat;
  logic [31:0] key, br_pc, br_tgt, slow_addr, ovr_addr, ovr_val, pend_addr, f_tgt;
  logic [1:0] br_src, f_src;
  logic stall_force, rand_stall, rand_br, do_flush, flushing, fired, ovr_en;

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .pcsource(pcsource), .bpc(bpc), .jrpc(jrpc), .jpc(jpc),
    .exc_flush(exc_flush), .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .o_inst(o_inst), .o_pc(o_pc),
    .o_valid(o_valid), .o_adel(o_adel)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  function automatic logic [31:0] rt();
    logic [31:0] r;
    r = 32'($urandom_range(255));
    return RST | (r << 2) | ($urandom_range(31) == 0 ? 32'd2 : 32'd0);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0; exc_flush = 1'b0; pcsource = 2'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    acc_pct = 100; lat_min = 1; lat_max = 1; key = '0;
    stall_force = 1'b0; rand_stall = 1'b0; rand_br = 1'b0; do_flush = 1'b0; flushing = 1'b0;
    br_pc = '1; br_src = 2'b0; br_tgt = '0; slow_addr = '1; slow_lat = 1; ovr_en = 1'b0;
    ovr_addr = '0; ovr_val = '0; pend_cnt = 0; fired = 1'b0;
    reqs.delete(); dq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // one cycle: drive decode side and SRAM slave at the falling edge
  task automatic tick();
    @(negedge clk);
    flushing = do_flush;
    do_flush = 1'b0;
    exc_flush = flushing;
    stall = flushing | stall_force | (rand_stall && $urandom_range(3) == 0);
    fired = o_valid && !stall;
    pcsource = 2'b0;
    if (rand_br) begin
      bpc = rt(); jrpc = rt(); jpc = rt();
      if (!fired) pcsource = 2'($urandom_range(3));
      else if ($urandom_range(99) < 15) pcsource = 2'($urandom_range(3, 1));
    end else if (fired && o_pc == br_pc) begin
      pcsource = br_src; bpc = br_tgt; jrpc = br_tgt; jpc = br_tgt;
    end
    f_src = pcsource;
    f_tgt = pcsource == 2'd1 ? bpc : pcsource == 2'd2 ? jrpc : jpc;
    if (fired) dq.push_back(deliv_t'{o_pc, o_inst, o_adel});
    inst_data_ok = 1'b0;
    inst_addr_ok = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        inst_data_ok = 1'b1;
        inst_rdata = (ovr_en && pend_addr == ovr_addr) ? ovr_val : pend_addr ^ key;
      end
    end
    if (inst_req && pend_cnt == 0 && !inst_data_ok && $urandom_range(99) < acc_pct) begin
      inst_addr_ok = 1'b1;
      reqs.push_back(inst_addr);
      pend_addr = inst_addr;
      pend_cnt = (inst_addr == slow_addr) ? slow_lat : int'($urandom_range(lat_max, lat_min));
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_valid, o_adel, inst_req} !== 3'b0 || o_inst !== '0 || o_pc !== '0) begin
      failures++;
      $display("FAIL reset_outputs valid=%b adel=%b req=%b inst=%h pc=%h, required all zero", o_valid, o_adel, inst_req, o_inst, o_pc);
    end
    tick();
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== RST) begin
      failures++;
      $display("FAIL first_req req=%b addr=%h, required 1 %h", inst_req, inst_addr, RST);
    end
  endtask

  task automatic test_basic();
    int first_valid = 0;
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3) begin
        checks++;
        if (o_pc !== RST || inst_req !== 1'b1 || inst_addr !== RST + 32'd4) begin
          failures++;
          $display("FAIL basic_overlap o_pc=%h req=%b addr=%h, required %h 1 %h", o_pc, inst_req, inst_addr, RST, RST + 32'd4);
        end
      end
      if (o_valid && first_valid == 0) first_valid = i;
    end
    checks++;
    if (first_valid != 3) begin
      failures++;
      $display("FAIL basic_first_valid cycle=%0d, required 3", first_valid);
    end
    checks++;
    if (reqs.size() < 3 || reqs[0] !== RST || reqs[1] !== RST + 32'd4 || reqs[2] !== RST + 32'd8) begin
      failures++;
      $display("FAIL basic_req_seq count=%0d, required BFC00000,BFC00004,BFC00008", reqs.size());
    end
    checks++;
    if (dq.size() < 4) begin
      failures++;
      $display("FAIL basic_deliveries count=%0d, required >=4", dq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (dq[k].pc !== RST + 32'(4 * k) || dq[k].inst !== RST + 32'(4 * k) || dq[k].adel !== 1'b0) begin
          failures++;
          $display("FAIL basic_word%0d pc=%h inst=%h adel=%b, required pc=inst=%h", k, dq[k].pc, dq[k].inst, dq[k].adel, RST + 32'(4 * k));
        end
      end
    end
  endtask

  task automatic test_stall();
    bit ok = 1;
    do_reset();
    repeat (2) tick();
    stall_force = 1'b1;
    repeat (4) tick();
    checks++;
    if (o_valid !== 1'b1 || o_pc !== RST || o_inst !== RST) begin
      failures++;
      $display("FAIL stall_frozen valid=%b pc=%h inst=%h, required 1 %h %h", o_valid, o_pc, o_inst, RST, RST);
    end
    checks++;
    if (reqs.size() != 2 || inst_req !== 1'b0) begin
      failures++;
      $display("FAIL stall_hold reqs=%0d req=%b, required 2 0", reqs.size(), inst_req);
    end
    stall_force = 1'b0;
    repeat (2) tick();
    checks++;
    if (o_valid !== 1'b1 || o_pc !== RST + 32'd4 || o_inst !== RST + 32'd4) begin
      failures++;
      $display("FAIL stall_parked valid=%b pc=%h inst=%h, required 1 %h", o_valid, o_pc, o_inst, RST + 32'd4);
    end
    repeat (8) tick();
    for (int k = 0; k < dq.size(); k++) if (dq[k].pc !== RST + 32'(4 * k)) ok = 0;
    checks++;
    if (!ok || dq.size() < 5) begin
      failures++;
      $display("FAIL stall_sequence count=%0d in_order=%0d, required >=5 consecutive PCs", dq.size(), ok);
    end
  endtask

  task automatic test_branch();
    for (int v = 0; v < 2; v++) begin
      int idx = -1;
      bit bad = 0;
      do_reset();
      br_pc = RST + 32'h10; br_src = 2'd1; br_tgt = RST + 32'h100;
      if (v == 1) begin slow_addr = RST + 32'h14; slow_lat = 4; end
      repeat (30) tick();
      for (int k = 0; k < dq.size(); k++) if (dq[k].pc == RST + 32'h10 && idx < 0) idx = k;
      checks++;
      if (idx < 0 || idx + 3 >= dq.size()) begin
        failures++;
        $display("FAIL branch%0d_progress branch_idx=%0d count=%0d", v, idx, dq.size());
      end else if (dq[idx+1].pc !== RST + 32'h14 || dq[idx+2].pc !== RST + 32'h100 || dq[idx+3].pc !== RST + 32'h104) begin
        failures++;
        $display("FAIL branch%0d_order got %h %h %h, required BFC00014 BFC00100 BFC00104", v, dq[idx+1].pc, dq[idx+2].pc, dq[idx+3].pc);
      end
      foreach (reqs[k]) if (reqs[k] == RST + 32'h18) bad = 1;
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL branch%0d_no_fallthrough BFC00018 requested=1, required 0", v);
      end
    end
  endtask

  task automatic test_jr();
    bit seen = 0, bad = 0;
    do_reset();
    br_pc = RST + 32'h10; br_src = 2'd2; br_tgt = RST + 32'h102;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!seen && o_valid && o_pc == RST + 32'h102) begin
        seen = 1;
        checks++;
        if (o_adel !== 1'b1 || o_inst !== '0) begin
          failures++;
          $display("FAIL jr_adel adel=%b inst=%h, required 1 00000000", o_adel, o_inst);
        end
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL jr_timeout misaligned pc never reached decode, required BFC00102");
    end
    foreach (reqs[k]) if (reqs[k][1:0] != 2'b0) bad = 1;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL jr_no_req misaligned request issued=1, required 0");
    end
  endtask

  task automatic test_flush();
    bit bad = 0;
    int idx = -1;
    do_reset();
    slow_addr = RST + 32'd8; slow_lat = 3;
    ovr_en = 1'b1; ovr_addr = RST + 32'd8; ovr_val = 32'hDEADBEEF;
    for (int i = 0; i < 20 && reqs.size() < 3; i++) tick();
    do_flush = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_valid && o_inst == 32'hDEADBEEF) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL flush_discard DEADBEEF reached o_inst, required never");
    end
    checks++;
    if (reqs.size() < 4 || reqs[3] !== EXC) begin
      failures++;
      $display("FAIL flush_refetch reqs=%0d, required 4th request at %h", reqs.size(), EXC);
    end
    for (int k = 0; k < dq.size(); k++) if (dq[k].pc == EXC && idx < 0) idx = k;
    checks++;
    if (idx < 0 || dq[idx].inst !== EXC) begin
      failures++;
      $display("FAIL flush_exc_word idx=%0d, required word at %h delivered with inst %h", idx, EXC, EXC);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    stall_force = 1'b1; slow_addr = RST + 32'd4; slow_lat = 6;
    for (int i = 0; i < 20 && reqs.size() < 2; i++) tick();
    tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({o_valid, o_adel, inst_req} !== 3'b0 || o_inst !== '0 || o_pc !== '0) begin
      failures++;
      $display("FAIL async_reset valid=%b adel=%b req=%b inst=%h pc=%h, required all zero", o_valid, o_adel, inst_req, o_inst, o_pc);
    end
    repeat (2) tick();
    reset = 1'b0;
    stall_force = 1'b0;
    reqs.delete(); dq.delete();
    repeat (20) tick();
    checks++;
    if (reqs.size() < 1 || reqs[0] !== RST) begin
      failures++;
      $display("FAIL reset_mid_first_req reqs=%0d, required first request at %h", reqs.size(), RST);
    end
    checks++;
    if (dq.size() < 1 || dq[0].pc !== RST || dq[0].inst !== RST) begin
      failures++;
      $display("FAIL reset_mid_first_word count=%0d, required pc=inst=%h", dq.size(), RST);
    end
  endtask

  // reference: delivered PC d[j+1] = target of d[j-1] if it redirected, else d[j]+4
  task automatic test_random();
    logic [31:0] e0 = RST, bt = '0, p_addr = '0, exp_inst;
    bit bv = 0, p_req = 0, p_ok = 0, p_fl = 0, bad = 0;
    int nfire = 0;
    do_reset();
    acc_pct = 60; lat_min = 1; lat_max = 3; rand_stall = 1'b1; rand_br = 1'b1; key = $urandom;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (p_req && !p_ok && !p_fl) begin
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== p_addr) begin
          failures++;
          $display("FAIL rand_req_stable cycle=%0d req=%b addr=%h, required 1 %h", i, inst_req, inst_addr, p_addr);
        end
      end
      p_req = inst_req; p_addr = inst_addr; p_ok = inst_addr_ok; p_fl = flushing;
      if (fired) begin
        nfire++;
        exp_inst = (e0[1:0] != 2'b0) ? 32'd0 : e0 ^ key;
        checks++;
        if (dq[$].pc !== e0 || dq[$].adel !== (e0[1:0] != 2'b0) || dq[$].inst !== exp_inst) begin
          failures++;
          $display("FAIL rand_word cycle=%0d pc=%h inst=%h adel=%b, required %h %h %b", i, dq[$].pc, dq[$].inst, dq[$].adel, e0, exp_inst, e0[1:0] != 2'b0);
        end
        e0 = bv ? bt : e0 + 32'd4;
        bv = f_src != 2'b0;
        bt = f_tgt;
      end
      if (flushing) begin
        e0 = EXC;
        bv = 0;
      end
      if ($urandom_range(99) < 2) do_flush = 1'b1;
    end
    checks++;
    if (nfire < 400) begin
      failures++;
      $display("FAIL rand_progress delivered=%0d, required >=400", nfire);
    end
    foreach (reqs[k]) if (reqs[k][1:0] != 2'b0) bad = 1;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL rand_aligned_reqs misaligned request issued=1, required 0");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_branch();
    test_jr();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
